// File: rtl/motor_seq_ctrl_pkg.sv
// rtl/motor_seq_ctrl_pkg.sv - state encoding and debug widths for motor_seq_ctrl
package motor_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PULSE  = 3'd1,
      SEEK   = 3'd2,
      WAIT_Y = 3'd3,
      HOLD   = 3'd4,
      FAIL   = 3'd5
   } mctrl_state_t;

   localparam int DBG_STATE_W = 3;
   localparam int DBG_MATCH_W = 8;

endpackage

// File: rtl/mctrl_pat_det.sv
// rtl/mctrl_pat_det.sv - overlapping serial pattern detector with fill tracking
module mctrl_pat_det #(
   parameter int               PAT_W   = 3,
   parameter logic [PAT_W-1:0] PATTERN = 3'b101
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   input  logic x,
   output logic match
);

   localparam int HW = (PAT_W > 1) ? PAT_W - 1 : 1;
   localparam int FW = $clog2(PAT_W + 1);

   // Only the newest PAT_W-1 bits are kept; the oldest bit never takes part in a compare.
   logic [HW-1:0]    r_hist;
   logic [FW-1:0]    r_fill;
   logic [PAT_W-1:0] w_window;

   generate
      if (PAT_W == 1) begin : g_single
         assign w_window = x;
      end else begin : g_multi
         assign w_window = {r_hist, x};
      end
   endgenerate

   assign match = en && (w_window == PATTERN) && (r_fill >= FW'(PAT_W - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (en) begin
         r_hist <= w_window[HW-1:0];
         if (r_fill != FW'(PAT_W))
            r_fill <= r_fill + 1'b1;
      end
   end

endmodule

// File: rtl/motor_seq_ctrl.sv
// rtl/motor_seq_ctrl.sv - motor-start supervisor: pulse, pattern seek, y window, hold/fail
// Optional debug ports state_dbg/match_cnt under MOTOR_SEQ_CTRL_DBG_EN.
module motor_seq_ctrl
   import motor_seq_ctrl_pkg::*;
#(
   parameter int               PAT_W   = 3,
   parameter logic [PAT_W-1:0] PATTERN = 3'b101,
   parameter int               TIMEOUT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic x,
   input  logic y,
   input  logic rearm,
`ifdef MOTOR_SEQ_CTRL_DBG_EN
   output logic [DBG_STATE_W-1:0] state_dbg,
   output logic [DBG_MATCH_W-1:0] match_cnt,
`endif
   output logic f,
   output logic g,
   output logic locked_on,
   output logic locked_off
);

   localparam int WCNT_W = $clog2(TIMEOUT + 1);

   mctrl_state_t      r_state;
   mctrl_state_t      w_next_state;
   logic [WCNT_W-1:0] r_wcnt;
   logic [WCNT_W-1:0] w_next_wcnt;
   logic              w_match;

   mctrl_pat_det #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_pat_det (
      .clk   (clk),
      .reset (reset),
      .clear (r_state != SEEK),
      .en    (r_state == SEEK),
      .x     (x),
      .match (w_match)
   );

   always_comb begin
      w_next_state = IDLE;
      w_next_wcnt  = '0;
      case (r_state)
         IDLE:   w_next_state = PULSE;
         PULSE:  w_next_state = SEEK;
         SEEK:   w_next_state = w_match ? WAIT_Y : SEEK;
         WAIT_Y: begin
            if (y)
               w_next_state = HOLD;
            else if (r_wcnt == WCNT_W'(TIMEOUT - 1))
               w_next_state = FAIL;
            else begin
               w_next_state = WAIT_Y;
               w_next_wcnt  = r_wcnt + 1'b1;
            end
         end
         HOLD:   w_next_state = rearm ? PULSE : HOLD;
         FAIL:   w_next_state = rearm ? PULSE : FAIL;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_next_state;
         r_wcnt  <= w_next_wcnt;
      end
   end

   assign f          = (r_state == PULSE);
   assign g          = (r_state == WAIT_Y) || (r_state == HOLD);
   assign locked_on  = (r_state == HOLD);
   assign locked_off = (r_state == FAIL);

`ifdef MOTOR_SEQ_CTRL_DBG_EN
   logic [DBG_MATCH_W-1:0] r_match_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         r_match_cnt <= '0;
      else if (w_match && (r_state == SEEK) && (r_match_cnt != '1))
         r_match_cnt <= r_match_cnt + 1'b1;
   end

   assign state_dbg = r_state;
   assign match_cnt = r_match_cnt;
`else
`endif

endmodule

// File: tb/tb_motor_seq_ctrl.sv
// tb/tb_motor_seq_ctrl.sv - directed self-checking bench for motor_seq_ctrl
module tb_motor_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset0 = 1'b1, x0 = 1'b0, y0 = 1'b0, rearm0 = 1'b0;
   logic reset1 = 1'b1, x1 = 1'b0, y1 = 1'b0, rearm1 = 1'b0;
   logic f0, g0, lon0, loff0;
   logic f1, g1, lon1, loff1;
   logic [3:0] w_out0, w_out1;
   int checks = 0;
   int errors = 0;

   assign w_out0 = {f0, g0, lon0, loff0};
   assign w_out1 = {f1, g1, lon1, loff1};

`ifdef MOTOR_SEQ_CTRL_DBG_EN
   logic [2:0] sdbg0, sdbg1;
   logic [7:0] mcnt0, mcnt1;
`endif

   motor_seq_ctrl u0 (
      .clk        (clk),
      .reset      (reset0),
      .x          (x0),
      .y          (y0),
      .rearm      (rearm0),
`ifdef MOTOR_SEQ_CTRL_DBG_EN
      .state_dbg  (sdbg0),
      .match_cnt  (mcnt0),
`endif
      .f          (f0),
      .g          (g0),
      .locked_on  (lon0),
      .locked_off (loff0)
   );

   motor_seq_ctrl #(.PAT_W(4), .PATTERN(4'b1100), .TIMEOUT(5)) u1 (
      .clk        (clk),
      .reset      (reset1),
      .x          (x1),
      .y          (y1),
      .rearm      (rearm1),
`ifdef MOTOR_SEQ_CTRL_DBG_EN
      .state_dbg  (sdbg1),
      .match_cnt  (mcnt1),
`endif
      .f          (f1),
      .g          (g1),
      .locked_on  (lon1),
      .locked_off (loff1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output nibble order everywhere: {f, g, locked_on, locked_off}.
   task automatic test_reset();
      logic [3:0] ev [8] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      reset0 = 1'b1; reset1 = 1'b1; x0 = 1'b0; y0 = 1'b0; rearm0 = 1'b0;
      tick();
      if (w_out0 !== 4'b0000) begin errors++; $display("FAIL reset_u0 got %b exp %b", w_out0, 4'b0000); end
      checks++;
      if (w_out1 !== 4'b0000) begin errors++; $display("FAIL reset_u1 got %b exp %b", w_out1, 4'b0000); end
      checks++;
`ifdef MOTOR_SEQ_CTRL_DBG_EN
      if (sdbg0 !== 3'd0 || mcnt0 !== 8'd0) begin errors++; $display("FAIL reset_dbg got %0d/%0d exp 0/0", sdbg0, mcnt0); end
      checks++;
`endif
      reset0 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (w_out0 !== ev[k]) begin errors++; $display("FAIL idle_seek edge %0d got %b exp %b", k, w_out0, ev[k]); end
         checks++;
      end
   endtask

   task automatic test_timeout_fail();
      logic       xv [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [3:0] ev [8] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
      reset0 = 1'b1; y0 = 1'b0; rearm0 = 1'b0; x0 = 1'b0;
      tick();
      reset0 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         x0 = xv[k];
         tick();
         if (w_out0 !== ev[k]) begin errors++; $display("FAIL timeout edge %0d got %b exp %b", k, w_out0, ev[k]); end
         checks++;
      end
   endtask

   task automatic test_overlap_hold();
      logic       xv [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic       yv [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] ev [9] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0110, 4'b0110};
      reset0 = 1'b1; rearm0 = 1'b0; x0 = 1'b0; y0 = 1'b0;
      tick();
      reset0 = 1'b0;
      for (int k = 0; k < 9; k++) begin
         x0 = xv[k];
         y0 = yv[k];
         tick();
         if (w_out0 !== ev[k]) begin errors++; $display("FAIL overlap edge %0d got %b exp %b", k, w_out0, ev[k]); end
         checks++;
      end
   endtask

   task automatic test_param_window();
      logic       xv [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       yv [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] ev [12] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                              4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0110};
      reset1 = 1'b1; rearm1 = 1'b0; x1 = 1'b0; y1 = 1'b0;
      tick();
      reset1 = 1'b0;
      for (int k = 0; k < 12; k++) begin
         x1 = xv[k];
         y1 = yv[k];
         tick();
         if (w_out1 !== ev[k]) begin errors++; $display("FAIL param edge %0d got %b exp %b", k, w_out1, ev[k]); end
         checks++;
      end
   endtask

   // Entered with u0 in FAIL.
   task automatic test_rearm();
      logic       rv [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic       xv [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       yv [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0] ev [10] = '{4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                              4'b0100, 4'b0100, 4'b0110, 4'b1000, 4'b0000};
      for (int k = 0; k < 10; k++) begin
         rearm0 = rv[k];
         x0 = xv[k];
         y0 = yv[k];
         tick();
         if (w_out0 !== ev[k]) begin errors++; $display("FAIL rearm edge %0d got %b exp %b", k, w_out0, ev[k]); end
         checks++;
      end
      rearm0 = 1'b0;
   endtask

   task automatic test_reset_override();
      logic xv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      reset0 = 1'b1; rearm0 = 1'b0; x0 = 1'b0; y0 = 1'b0;
      tick();
      reset0 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         x0 = xv[k];
         tick();
      end
      if (w_out0 !== 4'b0100) begin errors++; $display("FAIL ovr_wait got %b exp %b", w_out0, 4'b0100); end
      checks++;
      reset0 = 1'b1; y0 = 1'b1; rearm0 = 1'b1;
      tick();
      if (w_out0 !== 4'b0000) begin errors++; $display("FAIL ovr_reset1 got %b exp %b", w_out0, 4'b0000); end
      checks++;
      tick();
      if (w_out0 !== 4'b0000) begin errors++; $display("FAIL ovr_reset2 got %b exp %b", w_out0, 4'b0000); end
      checks++;
      reset0 = 1'b0;
      tick();
      if (w_out0 !== 4'b1000) begin errors++; $display("FAIL ovr_pulse got %b exp %b", w_out0, 4'b1000); end
      checks++;
      tick();
      if (w_out0 !== 4'b0000) begin errors++; $display("FAIL ovr_seek got %b exp %b", w_out0, 4'b0000); end
      checks++;
      rearm0 = 1'b0; y0 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_timeout_fail();
      test_rearm();
      test_overlap_hold();
      test_param_window();
      test_reset_override();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/motor_seq_ctrl.md
# motor_seq_ctrl

Parametrised motor-start supervisor. After reset it pulses `f` for one cycle. It then watches serial input `x` for a programmable bit pattern, and on a match asserts `g` and opens a programmable window in which `y` must respond. If `y` responds, `g` holds high; if the window expires, `g` drops. Unlike the fixed first-generation controller, the pattern, its length and the `y` window length are parameters, and a `rearm` input restarts the sequence without a reset. It sits between the sensor front-end and the motor driver enable.

## Interface
- `PAT_W`, default 3: pattern length in bits, ≥1.
- `PATTERN`, default `3'b101`: bit pattern on `x`. MSB is the first bit received.
- `TIMEOUT`, default 2: number of cycles `y` is sampled after a match, ≥1.
- `clk` in 1: single clock; all logic updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `x` in 1: serial sensor bit, sampled once per cycle in SEEK.
- `y` in 1: response bit, sampled in WAIT_Y.
- `rearm` in 1: restarts the sequence from HOLD or FAIL; ignored in every other state.
- `f` out 1: one-cycle start pulse; high only in PULSE.
- `g` out 1: motor enable; high in WAIT_Y and HOLD.
- `locked_on` out 1: high in HOLD.
- `locked_off` out 1: high in FAIL.

## Operation
- States: IDLE, PULSE, SEEK, WAIT_Y, HOLD, FAIL. All outputs are Moore outputs decoded from state.
- Reset: state goes to IDLE; history register, fill counter and window counter clear. All outputs are 0.
- IDLE always goes to PULSE. PULSE always goes to SEEK.
- SEEK: each cycle, `hist <= {hist[PAT_W-2:0], x}` and `fill` saturates at PAT_W.
  - A match is when `{hist[PAT_W-2:0], x} == PATTERN` and `fill >= PAT_W-1`. A match moves to WAIT_Y.
  - Detection is overlapping. Only bits sampled in the current SEEK visit count; `hist` and `fill` clear on entry to SEEK.
- WAIT_Y: `wcnt` counts 0..TIMEOUT-1.
  - `y=1` in any window cycle moves to HOLD on the next edge.
  - `y=0` on the cycle where `wcnt==TIMEOUT-1` moves to FAIL.
- HOLD and FAIL are absorbing. `rearm=1` moves to PULSE, so `f` pulses again and the full sequence repeats.
- `y` is ignored outside WAIT_Y. `x` is ignored outside SEEK.
- `reset` overrides everything, including `rearm`, in the same cycle and in any state.
- `wcnt` width is `$clog2(TIMEOUT+1)`. `fill` width is `$clog2(PAT_W+1)`.
- Illegal state encodings recover to IDLE on the next edge.

## Timing
- Cycle numbering: cycle 0 is the first edge with `reset=0`.
  - After cycle 0, state is PULSE, so `f=1` during cycle 1.
  - SEEK starts at cycle 2.
- The edge that samples the last pattern bit enters WAIT_Y, so `g=1` from the next cycle. Match-to-`g` latency is one edge.
- `g` stays high for exactly TIMEOUT cycles when `y` stays 0. The edge after the last window cycle enters FAIL.
- When `y=1` in a window cycle, `g` stays high continuously into HOLD, with no glitch.
- `rearm` sampled high in HOLD or FAIL gives `f=1` in the next cycle and `g=0` in that same cycle.

## Configuration
- `MOTOR_SEQ_CTRL_DBG_EN`
  - Defined: adds output `state_dbg`, 3 bits, carrying the state encoding from the package. Also adds a saturating 8-bit `match_cnt` output that counts SEEK-to-WAIT_Y transitions; only `reset` clears it.
  - Undefined: neither port exists, and function is identical.

## Structure
- Package `motor_seq_ctrl_pkg`:
  - state enum typedef `mctrl_state_t`, with IDLE=0, PULSE=1, SEEK=2, WAIT_Y=3, HOLD=4, FAIL=5;
  - the debug width constants.
- Sub-module `mctrl_pat_det`: history shift register, fill counter and match compare.
  - Parameters: `PAT_W`, `PATTERN`.
  - Inputs: `clear` and `en`.
  - Output: combinational `match`.

## Test plan
- Reset release with defaults, `x=0`, `y=0`: `f=1` only in cycle 1; `g=0` throughout; state stays SEEK.
- Defaults, `x` = 1,0,1 from cycle 2 and `y=0`: `g=1` for cycles 5–6; `locked_off=1` from cycle 7.
- Defaults, `x` = 1,1,0,1, then `y=0`,1 in the window: the overlapping match is found; `g` is high continuously from the cycle after the final 1; `locked_on` is asserted.
- `PAT_W=4`, `PATTERN=4'b1100`, `TIMEOUT=5`, `y=1` in window cycle 4: HOLD is entered; `g` is never low after the match.
- From FAIL, `rearm=1` for one cycle: `f=1` next cycle, then SEEK; a repeat 1,0,1 with `y=1` reaches HOLD. `rearm` pulses in SEEK and WAIT_Y have no effect.
- `reset=1` asserted during WAIT_Y with `y=1`: IDLE next cycle, all outputs 0; `rearm=1` together with `reset=1` still gives IDLE.
